// File: rtl/sa_pkg.sv
// Shared systolic-array constants and the mover scheduler state encoding.
// The size defaults are also used by the data mover, so both blocks agree on tile geometry.
package sa_pkg;

  localparam int PE_SIZE_DEF   = 16;
  localparam int OC_DEF        = 64;
  localparam int NUM_TILES_DEF = 56;
  localparam int TIMEOUT_DEF   = 1024;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_PUSH  = 3'd2,
    S_DRAIN = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } sched_state_t;

endpackage

// File: rtl/sa_sched_cnt.sv
// Loadable down-counter with a zero flag; it saturates at zero instead of wrapping.
// A load overrides the decrement, and clr overrides both.
module sa_sched_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/sa_mover_scheduler.sv
// Sequences the SA output data mover tile by tile over a whole layer.
// For each tile it issues one PE_SIZE-cycle enable burst, then waits out the skew and write phase. After the last tile it waits for the mover to report finish.
module sa_mover_scheduler
  import sa_pkg::*;
#(
  parameter int PE_SIZE   = PE_SIZE_DEF,
  parameter int OC        = OC_DEF,
  parameter int NUM_TILES = NUM_TILES_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic                           tile_ready_i,
  input  logic                           mover_finish_i,
  output logic                           mover_en_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [$clog2(NUM_TILES+1)-1:0] tile_idx_o
);

  localparam int BW = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
  localparam int WW = $clog2(PE_SIZE + OC + TIMEOUT);
  localparam int TW = $clog2(NUM_TILES + 1);

  // Counters hold N-1 on entry and leave the state on the cycle they read zero.
  localparam logic [BW-1:0] BURST_LOAD   = BW'(PE_SIZE - 1);
  localparam logic [WW-1:0] DRAIN_LOAD   = WW'(PE_SIZE + OC - 2);
  localparam logic [WW-1:0] TIMEOUT_LOAD = WW'(TIMEOUT - 1);
  localparam logic [TW-1:0] LAST_TILE    = TW'(NUM_TILES - 1);

  sched_state_t  state;
  logic          burst_load, burst_dec, burst_zero;
  logic          wait_load, wait_dec, wait_zero;
  logic [WW-1:0] wait_val;
  logic          more_tiles;

  assign busy_o     = (state != S_IDLE);
  assign more_tiles = (tile_idx_o < LAST_TILE);

  always_comb begin
    burst_load = (state == S_WAIT) && tile_ready_i;
    burst_dec  = (state == S_PUSH);
    wait_dec   = (state == S_DRAIN) || (state == S_FINAL);
    wait_load  = 1'b0;
    wait_val   = DRAIN_LOAD;
    if (state == S_PUSH && burst_zero) begin
      wait_load = 1'b1;
    end else if (state == S_DRAIN && wait_zero && !more_tiles) begin
      wait_load = 1'b1;
      wait_val  = TIMEOUT_LOAD;
    end
  end

  sa_sched_cnt #(.W(BW)) u_burst_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort_i),
    .load     (burst_load),
    .load_val (BURST_LOAD),
    .dec      (burst_dec),
    .zero     (burst_zero)
  );

  sa_sched_cnt #(.W(WW)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort_i),
    .load     (wait_load),
    .load_val (wait_val),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mover_en_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      tile_idx_o <= '0;
    end else if (abort_i) begin
      state      <= S_IDLE;
      mover_en_o <= 1'b0;
      done_o     <= 1'b0;
      tile_idx_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state      <= S_WAIT;
            tile_idx_o <= '0;
            err_o      <= 1'b0;
          end
        end
        S_WAIT: begin
          if (tile_ready_i) begin
            state      <= S_PUSH;
            mover_en_o <= 1'b1;
          end
        end
        S_PUSH: begin
          if (burst_zero) begin
            state      <= S_DRAIN;
            mover_en_o <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (wait_zero) begin
            if (more_tiles) begin
              tile_idx_o <= tile_idx_o + TW'(1);
              state      <= S_WAIT;
            end else begin
              state <= S_FINAL;
            end
          end
        end
        S_FINAL: begin
          // A finish arriving on the expiry cycle is still a clean finish.
          if (mover_finish_i) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else if (wait_zero) begin
            state  <= S_DONE;
            done_o <= 1'b1;
            err_o  <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_mover_scheduler.sv
// Directed bench: a default-size scheduler (dut a) and a small single-tile one (dut b, 4x4, OC=8, TIMEOUT=16).
module tb_sa_mover_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b0, a_finish = 1'b0;
  logic       a_en, a_busy, a_done, a_err;
  logic [5:0] a_idx;

  logic       b_rst = 1'b1, b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0, b_finish = 1'b0;
  logic       b_en, b_busy, b_done, b_err;
  logic [0:0] b_idx;

  int n_checks = 0;
  int n_errors = 0;

  sa_mover_scheduler dut_a (
    .clk            (clk),
    .rst            (a_rst),
    .start_i        (a_start),
    .abort_i        (a_abort),
    .tile_ready_i   (a_ready),
    .mover_finish_i (a_finish),
    .mover_en_o     (a_en),
    .busy_o         (a_busy),
    .done_o         (a_done),
    .err_o          (a_err),
    .tile_idx_o     (a_idx)
  );

  sa_mover_scheduler #(.PE_SIZE(4), .OC(8), .NUM_TILES(1), .TIMEOUT(16)) dut_b (
    .clk            (clk),
    .rst            (b_rst),
    .start_i        (b_start),
    .abort_i        (b_abort),
    .tile_ready_i   (b_ready),
    .mover_finish_i (b_finish),
    .mover_en_o     (b_en),
    .busy_o         (b_busy),
    .done_o         (b_done),
    .err_o          (b_err),
    .tile_idx_o     (b_idx)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic measure_gap(output int n);
    n = 0;
    while (a_en === 1'b0 && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic measure_burst(output int n);
    n = 0;
    while (a_en === 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  // Gap = 79 DRAIN cycles + 1 WAIT cycle between bursts; only WAIT right after start.
  task automatic run_bursts(input int first, input int last, input int first_gap);
    int g, b;
    for (int t = first; t <= last; t++) begin
      measure_gap(g);
      chk($sformatf("gap_t%0d", t), g, (t == first) ? first_gap : 80);
      chk($sformatf("idx_t%0d", t), int'(a_idx), t);
      measure_burst(b);
      chk($sformatf("burst_t%0d", t), b, 16);
    end
  endtask

  initial begin
    int n;
    tick();
    tick();
    chk("rst_a_en", a_en, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_idx", int'(a_idx), 0);
    chk("rst_b_busy", b_busy, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    a_ready = 1'b1;
    tick();

    // Full layer, finish on the 5th FINAL cycle; an early finish in DRAIN is ignored.
    start_a();
    chk("t1_busy", a_busy, 1);
    run_bursts(0, 55, 1);
    a_finish = 1'b1;
    repeat (10) tick();
    a_finish = 1'b0;
    repeat (68) tick();
    chk("t1_drain_busy", a_busy, 1);
    tick();
    repeat (3) tick();
    chk("t1_f4_done", a_done, 0);
    chk("t1_f4_busy", a_busy, 1);
    tick();
    a_finish = 1'b1;
    tick();
    a_finish = 1'b0;
    chk("t1_done", a_done, 1);
    chk("t1_done_err", a_err, 0);
    chk("t1_done_busy", a_busy, 1);
    tick();
    chk("t1_after_done", a_done, 0);
    chk("t1_after_busy", a_busy, 0);

    // Tile 3 held in WAIT for 20 extra cycles; start pulse mid-burst; abort in tile 10.
    start_a();
    run_bursts(0, 2, 1);
    a_ready = 1'b0;
    repeat (79) tick();
    chk("t2_w1_idx", int'(a_idx), 3);
    chk("t2_w1_en", a_en, 0);
    chk("t2_w1_busy", a_busy, 1);
    repeat (20) tick();
    chk("t2_w21_idx", int'(a_idx), 3);
    chk("t2_w21_en", a_en, 0);
    a_ready = 1'b1;
    measure_gap(n);
    chk("t2_last_wait", n, 1);
    chk("t2_idx3", int'(a_idx), 3);
    measure_burst(n);
    chk("t2_burst3", n, 16);
    run_bursts(4, 4, 80);
    measure_gap(n);
    chk("t5_gap5", n, 80);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("t5_idx5", int'(a_idx), 5);
    measure_burst(n);
    chk("t5_burst5_rest", n, 15);
    run_bursts(6, 9, 80);
    measure_gap(n);
    chk("t4_gap10", n, 80);
    chk("t4_idx10", int'(a_idx), 10);
    repeat (6) tick();
    chk("t4_en7", a_en, 1);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("t4_abort_en", a_en, 0);
    chk("t4_abort_busy", a_busy, 0);
    chk("t4_abort_idx", int'(a_idx), 0);
    chk("t4_abort_done", a_done, 0);

    // Finish never comes: timeout after 1024 FINAL cycles.
    start_a();
    run_bursts(0, 55, 1);
    repeat (79) tick();
    repeat (1023) tick();
    chk("t3_f1024_err", a_err, 0);
    chk("t3_f1024_done", a_done, 0);
    chk("t3_f1024_busy", a_busy, 1);
    tick();
    chk("t3_to_err", a_err, 1);
    chk("t3_to_done", a_done, 1);
    tick();
    chk("t3_idle_done", a_done, 0);
    chk("t3_idle_busy", a_busy, 0);
    chk("t3_err_sticky", a_err, 1);
    a_start = 1'b1;
    a_abort = 1'b1;
    tick();
    a_start = 1'b0;
    a_abort = 1'b0;
    chk("t5_abort_wins_busy", a_busy, 0);
    chk("t5_abort_keeps_err", a_err, 1);
    start_a();
    chk("t3_restart_busy", a_busy, 1);
    chk("t3_restart_err", a_err, 0);
    chk("t3_restart_idx", int'(a_idx), 0);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("t3_abort_busy", a_busy, 0);
    chk("t3_abort_en", a_en, 0);

    // Single 4x4 tile, OC=8: finish on the 16th FINAL cycle is clean.
    b_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("t6_w1_en", b_en, 0);
    chk("t6_w1_busy", b_busy, 1);
    tick();
    chk("t6_p1_en", b_en, 1);
    chk("t6_p1_idx", int'(b_idx), 0);
    n = 0;
    while (b_en === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("t6_burst", n, 4);
    repeat (10) tick();
    chk("t6_d11_en", b_en, 0);
    chk("t6_d11_done", b_done, 0);
    chk("t6_d11_idx", int'(b_idx), 0);
    tick();
    repeat (15) tick();
    chk("t6_f16_done", b_done, 0);
    b_finish = 1'b1;
    tick();
    b_finish = 1'b0;
    chk("t6_done", b_done, 1);
    chk("t6_done_err", b_err, 0);
    tick();
    chk("t6_idle_busy", b_busy, 0);
    chk("t6_idle_done", b_done, 0);

    // Same layer with no finish: error only after the 16th FINAL cycle.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    repeat (4) tick();
    repeat (10) tick();
    tick();
    repeat (15) tick();
    chk("t6_to_f16_err", b_err, 0);
    chk("t6_to_f16_done", b_done, 0);
    tick();
    chk("t6_to_err", b_err, 1);
    chk("t6_to_done", b_done, 1);
    tick();
    chk("t6_to_sticky", b_err, 1);

    // Reset during the burst drops the enable on the next edge.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    tick();
    chk("rstp_en_before", b_en, 1);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    chk("rstp_en", b_en, 0);
    chk("rstp_busy", b_busy, 0);
    chk("rstp_err", b_err, 0);
    chk("rstp_idx", int'(b_idx), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
